// File: rtl/convolution.sv
// convolution - streaming 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16).
//
// Accepts one raster-order pixel per clock and emits one filtered pixel per
// clock with a status code. Two ROW_SIZE-deep circular line buffers provide
// the two rows above the incoming pixel. A 3x3 window shifts left on every
// accepted pixel.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   inputPixel   pixel accepted on every rising edge while rst=1
//   outputPixel  registered filtered pixel (0 unless valid=2'b01)
//   valid        registered status: 00 priming, 01 interior, 10 row-wrap edge
//
// Build option: define CONV_ROUND_EN for round-half-up ((sum+8)>>4);
// the default build truncates (sum>>4).

module convolution #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic [1:0]           valid
);

  localparam int CW = (ROW_SIZE > 2) ? $clog2(ROW_SIZE) : 2;
  localparam int SW = WORD_SIZE + 4;
  localparam logic [CW-1:0] LAST_COL = CW'(ROW_SIZE - 1);

  logic [CW-1:0]        r_col;
  logic [1:0]           r_row;
  // Row/column of the pixel currently at the window's bottom-right corner.
  logic [CW-1:0]        r_win_col;
  logic [1:0]           r_win_row;

  logic [WORD_SIZE-1:0] r_lb0 [ROW_SIZE];
  logic [WORD_SIZE-1:0] r_lb1 [ROW_SIZE];
  logic [WORD_SIZE-1:0] r_win [3][3];

  logic [WORD_SIZE-1:0] w_lb0_out;
  logic [WORD_SIZE-1:0] w_lb1_out;
  logic [SW-1:0]        w_sum;
  logic [WORD_SIZE-1:0] w_result;

  // Read-before-write at the same column address: the old entry is the pixel
  // one (LB0) or two (LB1) rows above the incoming pixel.
  assign w_lb0_out = r_lb0[r_col];
  assign w_lb1_out = r_lb1[r_col];

  // Line-buffer RAM is never cleared; stale contents are masked by the
  // priming status until two fresh rows have been written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lb0[r_col] <= inputPixel;
      r_lb1[r_col] <= w_lb0_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win_col <= '0;
      r_win_row <= '0;
    end else begin
      r_win_col <= r_col;
      r_win_row <= r_row;
      if (r_col == LAST_COL) begin
        r_col <= '0;
        if (r_row != 2'd2) r_row <= r_row + 2'd1;
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Window rows: [0] top (two rows up), [1] middle, [2] bottom (current row).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb1_out;
      r_win[1][2] <= w_lb0_out;
      r_win[2][2] <= inputPixel;
    end
  end

  always_comb begin
    w_sum = SW'(r_win[0][0])        + (SW'(r_win[0][1]) << 1) + SW'(r_win[0][2])
          + (SW'(r_win[1][0]) << 1) + (SW'(r_win[1][1]) << 2) + (SW'(r_win[1][2]) << 1)
          + SW'(r_win[2][0])        + (SW'(r_win[2][1]) << 1) + SW'(r_win[2][2]);
  end

`ifdef CONV_ROUND_EN
  // Max (4080 + 8) >> 4 = 255, so rounding never overflows WORD_SIZE.
  assign w_result = WORD_SIZE'((w_sum + SW'(8)) >> 4);
`else
  assign w_result = WORD_SIZE'(w_sum >> 4);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      outputPixel <= '0;
      valid       <= 2'b00;
    end else if (r_win_row < 2'd2) begin
      outputPixel <= '0;
      valid       <= 2'b00;
    end else if (r_win_col < CW'(2)) begin
      // Window still straddles the previous row's right edge.
      outputPixel <= '0;
      valid       <= 2'b10;
    end else begin
      outputPixel <= w_result;
      valid       <= 2'b01;
    end
  end

endmodule

// File: tb/tb_convolution.sv
module tb_convolution;

  localparam int W  = 8;
  localparam int RS = 8;

  typedef struct packed {
    logic [W-1:0] pix;
    logic [1:0]   vld;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] inputPixel = '0;
  logic [W-1:0] outputPixel;
  logic [1:0]   valid;

  int tests = 0;
  int fails = 0;

  exp_t         exp_q[$];
  exp_t         obs[$];
  int unsigned  hist[$];
  exp_t         prev = '0;
  int           n_push = 0;

  convolution #(.WORD_SIZE(W), .ROW_SIZE(RS)) dut (
    .clk(clk), .rst(rst), .inputPixel(inputPixel),
    .outputPixel(outputPixel), .valid(valid)
  );

  always #5 clk = ~clk;

  // Reference: output for the pixel at stream index k since the last reset,
  // computed directly from the image history.
  function automatic exp_t model(input int k);
    exp_t e;
    int r, c, sum, wgt;
    r = k / RS;
    c = k % RS;
    e = '0;
    if (r < 2) return e;
    if (c < 2) begin e.vld = 2'b10; return e; end
    sum = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        wgt = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
        sum += wgt * int'(hist[k - (2 - dr) * RS - (2 - dc)]);
      end
`ifdef CONV_ROUND_EN
    sum += 8;
`endif
    e.pix = W'(sum >> 4);
    e.vld = 2'b01;
    return e;
  endfunction

  // Drive one edge; queue what the DUT must show right after that edge.
  task automatic step(input logic rv, input logic [W-1:0] px);
    exp_t e;
    @(negedge clk);
    rst = rv;
    inputPixel = px;
    e = rv ? prev : exp_t'(0);
    exp_q.push_back(e);
    n_push++;
    if (rv) begin
      hist.push_back(int'(px));
      prev = model(hist.size() - 1);
    end else begin
      hist.delete();
      prev = '0;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs.push_back('{pix: outputPixel, vld: valid});
        tests++;
        if (outputPixel !== e.pix || valid !== e.vld) begin
          fails++;
          $display("FAIL scoreboard[%0d]: got pix=%0d valid=%b, expected pix=%0d valid=%b",
                   obs.size() - 1, outputPixel, valid, e.pix, e.vld);
        end
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [W-1:0] ep,
                     input logic [1:0] ev);
    tests++;
    if (idx >= obs.size()) begin
      fails++;
      $display("FAIL %s: output %0d never observed, expected pix=%0d valid=%b",
               name, idx, ep, ev);
    end else if (obs[idx].pix !== ep || obs[idx].vld !== ev) begin
      fails++;
      $display("FAIL %s: got pix=%0d valid=%b, expected pix=%0d valid=%b",
               name, obs[idx].pix, obs[idx].vld, ep, ev);
    end
  endtask

`ifdef CONV_ROUND_EN
  localparam logic [W-1:0] IMP_C = 8'd64, IMP_E = 8'd32, IMP_D = 8'd16;
`else
  localparam logic [W-1:0] IMP_C = 8'd63, IMP_E = 8'd31, IMP_D = 8'd15;
`endif

  initial begin
    int base_const, base_imp, first01;

    // Reset with random input.
    for (int i = 0; i < 2; i++) step(1'b0, W'($urandom));

    // Constant 100: priming, edge codes, first interior output timing.
    base_const = n_push;
    for (int i = 0; i < 40; i++) step(1'b1, 8'd100);

    // Impulse of 255 at (3,3).
    step(1'b0, 8'd0);
    base_imp = n_push;
    for (int k = 0; k < 7 * RS; k++) step(1'b1, (k == 3 * RS + 3) ? 8'd255 : 8'd0);

    // All-max.
    step(1'b0, 8'd0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'd255);

    // Random stream with a reset during row 4.
    step(1'b0, 8'd0);
    for (int i = 0; i < 4 * RS + 3; i++) step(1'b1, W'($urandom));
    step(1'b0, W'($urandom));
    for (int i = 0; i < 4 * RS; i++) step(1'b1, W'($urandom));

    // Horizontal gradient.
    step(1'b0, 8'd0);
    for (int k = 0; k < 5 * RS; k++) step(1'b1, W'(10 * (k % RS)));

    // Long random stream (row counter saturated).
    step(1'b0, 8'd0);
    for (int i = 0; i < 30 * RS; i++) step(1'b1, W'($urandom));

    repeat (3) @(posedge clk);
    #2;

    // Directed checks; output for pixel k appears at obs index base + k + 1.
    chk("prime_last00", base_const + 15 + 1, 8'd0, 2'b00);
    chk("edge_col0",    base_const + 16 + 1, 8'd0, 2'b10);
    chk("edge_col1",    base_const + 17 + 1, 8'd0, 2'b10);
    chk("first_valid",  base_const + 18 + 1, 8'd100, 2'b01);
    first01 = -1;
    for (int i = base_const; i < base_const + 40 && i < obs.size(); i++)
      if (first01 < 0 && obs[i].vld == 2'b01) first01 = i - base_const;
    tests++;
    if (first01 != 19) begin
      fails++;
      $display("FAIL first01_index: got %0d, expected 19", first01);
    end
    chk("imp_centre", base_imp + (4 * RS + 4) + 1, IMP_C, 2'b01);
    chk("imp_right",  base_imp + (4 * RS + 5) + 1, IMP_E, 2'b01);
    chk("imp_left",   base_imp + (4 * RS + 3) + 1, IMP_E, 2'b01);
    chk("imp_up",     base_imp + (3 * RS + 4) + 1, IMP_E, 2'b01);
    chk("imp_down",   base_imp + (5 * RS + 4) + 1, IMP_E, 2'b01);
    chk("imp_diag_ul", base_imp + (3 * RS + 3) + 1, IMP_D, 2'b01);
    chk("imp_diag_dr", base_imp + (5 * RS + 5) + 1, IMP_D, 2'b01);
    chk("imp_far",    base_imp + (5 * RS + 7) + 1, 8'd0, 2'b01);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d outputs left unchecked, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
